ram_stream_reader: RTL and testbench

Sequential read-back engine for the data RAM window of the memory map (byte addresses 31000..61029, DEPTH = 30030 words). The processor writes results into that window through the memory controller. This block is the matching reader: on a start pulse it walks a contiguous range of the window through a synchronous read port and streams each word out on a valid/ready interface toward a display or serial sink. A 2-entry output FIFO absorbs the 1-cycle read latency, so the block sustains one word per cycle under backpressure.

---
 rtl/ram_stream_reader.sv | 154 +++++++++++++++
 tb/tb_ram_stream_reader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : ram_stream_reader
// Purpose  : Sequential read-back engine for the data RAM window. On a start
//            pulse it walks a clamped, contiguous range of the window through
//            a synchronous (1-cycle latency) read port and streams each word
//            out on a valid/ready interface. A 2-entry output FIFO absorbs the
//            read latency so one word per cycle is sustained under backpressure.
// Ports    : clk, rst (async, active-low)
//            start/offset/count  - transfer request (sampled only when idle)
//            mem_re/mem_addr     - RAM read strobe and address
//            mem_rd              - RAM read data, valid the cycle after mem_re
//            out_data/out_valid/out_ready - streamed word handshake
//            busy                - transfer in progress
//            done                - one-cycle pulse when a transfer completes
// Revision : 1.0 - initial release
// ============================================================================
module ram_stream_reader #(
  parameter int unsigned S     = 32,
  parameter int unsigned DW    = 8,
  parameter int unsigned BASE  = 31000,
  parameter int unsigned DEPTH = 30030
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [S-1:0]  offset,
  input  logic [S-1:0]  count,
  output logic          mem_re,
  output logic [S-1:0]  mem_addr,
  input  logic [DW-1:0] mem_rd,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  localparam logic [S-1:0] C_BASE  = S'(BASE);
  localparam logic [S-1:0] C_DEPTH = S'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  logic [S-1:0]  r_index;
  logic [S-1:0]  r_remaining;
  logic [S-1:0]  r_addr_hold;
  logic          r_inflight;
  logic          r_done;
  logic [DW-1:0] r_fifo [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_fifo_count;

  logic          w_pop;
  logic          w_issue;
  logic [S-1:0]  w_window_left;
  logic [S-1:0]  w_len;

  // Clamp the request to the window before any address arithmetic, so
  // BASE+index can never leave the window.
  always_comb begin
    w_window_left = C_DEPTH - offset;
    w_len         = '0;
    if (offset < C_DEPTH) begin
      w_len = (count < w_window_left) ? count : w_window_left;
    end
  end

  assign out_valid = (r_fifo_count != 2'd0);
  assign out_data  = r_fifo[r_rd_ptr];
  assign w_pop     = out_valid & out_ready;

  // A read may only issue if its data is guaranteed a FIFO slot when it
  // returns: current occupancy plus the word already in flight, less the
  // word leaving this cycle, must be below 2.
  assign w_issue = (r_state == ST_RUN) && (r_remaining != '0) &&
                   (({1'b0, r_fifo_count} + {2'b00, r_inflight}) <
                    (3'd2 + {2'b00, w_pop}));

  assign mem_re   = w_issue;
  assign mem_addr = w_issue ? (C_BASE + r_index) : r_addr_hold;
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_index      <= '0;
      r_remaining  <= '0;
      r_addr_hold  <= '0;
      r_inflight   <= 1'b0;
      r_done       <= 1'b0;
      r_fifo[0]    <= '0;
      r_fifo[1]    <= '0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_fifo_count <= 2'd0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;

      if (w_issue) begin
        r_addr_hold <= C_BASE + r_index;
        r_index     <= r_index + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end

      // Returning read data is pushed unconditionally; the issue rule above
      // guarantees a free slot, even when full and popping in the same cycle.
      if (r_inflight) begin
        r_fifo[r_wr_ptr] <= mem_rd;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_fifo_count <= r_fifo_count + {1'b0, r_inflight} - {1'b0, w_pop};

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state     <= ST_RUN;
              r_index     <= offset;
              r_remaining <= w_len;
            end
          end
        end
        ST_RUN: begin
          if (w_issue && (r_remaining == {{(S-1){1'b0}}, 1'b1})) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Finished once nothing is in flight and the last stored word leaves.
          if (!r_inflight && (r_fifo_count == 2'd1) && w_pop) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_stream_reader
// Purpose  : Self-checking bench for ram_stream_reader. Expected read
//            addresses and words are queued when a transfer is requested; a
//            monitor on the falling edge compares every read strobe and every
//            accepted output word, and tracks buffer occupancy and done timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_stream_reader;

  localparam int S     = 32;
  localparam int DW    = 8;
  localparam int BASE  = 31000;
  localparam int DEPTH = 30030;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [S-1:0]  offset = '0;
  logic [S-1:0]  count = '0;
  logic          mem_re;
  logic [S-1:0]  mem_addr;
  logic [DW-1:0] mem_rd = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;
  logic          done;

  ram_stream_reader #(.S(S), .DW(DW), .BASE(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .offset(offset), .count(count),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RAM contents: word at address a is (a - BASE + 0x10 + salt).
  logic [7:0] salt = 8'h00;
  function automatic logic [7:0] ram_val(input logic [31:0] a);
    logic [31:0] v;
    v = a - 32'(BASE) + 32'h10 + {24'b0, salt};
    return v[7:0];
  endfunction

  always @(posedge clk) if (mem_re) mem_rd <= ram_val(mem_addr);

  // Scoreboard queues and monitor state
  logic [7:0]  exp_data_q[$];
  logic [31:0] exp_addr_q[$];
  int  occ = 0;
  bit  prev_re = 1'b0;
  bit  stalled = 1'b0;
  logic [7:0] stall_data;
  int  dones_seen = 0;
  int  last_pop_cyc = 0;
  int  first_re_cyc = -1;
  int  first_pop_cyc = -1;
  bit  zero_len = 1'b0;
  int  t_start = 0;

  always @(negedge clk) begin : mon
    bit          pop;
    logic [31:0] ea;
    logic [7:0]  ed;
    if (rst) begin
      pop = out_valid && out_ready;
      if (done) begin
        dones_seen++;
        check(busy == 1'b0, "busy_low_at_done", busy, 0);
        if (zero_len) check(cyc == t_start + 1, "done_cycle_len0", cyc, t_start + 1);
        else          check(cyc == last_pop_cyc + 1, "done_cycle", cyc, last_pop_cyc + 1);
      end
      if (zero_len) check(busy == 1'b0 && mem_re == 1'b0, "idle_len0", {busy, mem_re}, 0);
      if (mem_re) begin
        if (first_re_cyc < 0) first_re_cyc = cyc;
        check(occ + int'(prev_re) - int'(pop) < 2, "space_rule",
              occ + int'(prev_re) - int'(pop), 1);
        if (exp_addr_q.size() == 0) begin
          check(1'b0, "unexpected_read", mem_addr, 0);
        end else begin
          ea = exp_addr_q.pop_front();
          check(mem_addr == ea, "mem_addr", mem_addr, ea);
        end
      end
      if (stalled && out_valid)
        check(out_data == stall_data, "stall_stable", out_data, stall_data);
      if (pop) begin
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        if (exp_data_q.size() == 0) begin
          check(1'b0, "unexpected_word", out_data, 0);
        end else begin
          ed = exp_data_q.pop_front();
          check(out_data == ed, "out_data", out_data, ed);
        end
      end
      stalled    = out_valid && !out_ready;
      stall_data = out_data;
      occ        = occ + int'(prev_re) - int'(pop);
      prev_re    = mem_re;
    end else begin
      occ     = 0;
      prev_re = 1'b0;
      stalled = 1'b0;
    end
  end

  function automatic int ref_len(input logic [31:0] off, input logic [31:0] cnt);
    longint left;
    if (off >= 32'(DEPTH)) return 0;
    left = longint'(DEPTH) - longint'(off);
    return (longint'(cnt) < left) ? int'(cnt) : int'(left);
  endfunction

  task automatic queue_expect(input logic [31:0] off, input int len);
    for (int i = 0; i < len; i++) begin
      exp_addr_q.push_back(32'(BASE) + off + 32'(i));
      exp_data_q.push_back(ram_val(32'(BASE) + off + 32'(i)));
    end
  endtask

  // ready_mode: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random
  task automatic run_xfer(input logic [31:0] off, input logic [31:0] cnt,
                          input int ready_mode, input bit repulse);
    int len;
    int target;
    bit finished;
    len = ref_len(off, cnt);
    queue_expect(off, len);
    target        = dones_seen + 1;
    first_re_cyc  = -1;
    first_pop_cyc = -1;
    finished      = 1'b0;
    @(posedge clk); #1;
    zero_len  = (len == 0);
    start     = 1'b1;
    offset    = off;
    count     = cnt;
    out_ready = (ready_mode != 2) ? 1'b1 : 1'($urandom_range(0, 1));
    t_start   = cyc;
    for (int n = 0; n < 400 && !finished; n++) begin
      @(posedge clk); #1;
      start = repulse && (cyc == t_start + 2 || cyc == t_start + 5);
      if (start) begin
        offset = $urandom_range(0, DEPTH - 1);
        count  = $urandom_range(1, 20);
      end
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((n + 1) % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (exp_data_q.size() == 0 && dones_seen >= target) finished = 1'b1;
    end
    check(finished, "xfer_timeout", exp_data_q.size(), 0);
    check(dones_seen == target, "done_count", dones_seen, target);
    check(exp_addr_q.size() == 0, "reads_issued", exp_addr_q.size(), 0);
    if (ready_mode == 0 && len > 0) begin
      check(first_re_cyc == t_start + 1, "first_read_cycle", first_re_cyc, t_start + 1);
      check(first_pop_cyc == t_start + 3, "first_word_cycle", first_pop_cyc, t_start + 3);
      check(last_pop_cyc == first_pop_cyc + len - 1, "no_bubbles",
            last_pop_cyc, first_pop_cyc + len - 1);
    end
    zero_len  = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    exp_data_q.delete();
    exp_addr_q.delete();
  endtask

  initial begin
    int base_dones;
    logic [31:0] off;
    logic [31:0] cnt;

    #2 rst = 1'b0;
    #1;
    check(mem_re == 0,    "rst_mem_re",    mem_re, 0);
    check(mem_addr == 0,  "rst_mem_addr",  mem_addr, 0);
    check(out_valid == 0, "rst_out_valid", out_valid, 0);
    check(out_data == 0,  "rst_out_data",  out_data, 0);
    check(busy == 0,      "rst_busy",      busy, 0);
    check(done == 0,      "rst_done",      done, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    // Directed cases
    salt = 8'h00;
    run_xfer(32'd0, 32'd4, 0, 1'b0);          // words 0x10..0x13
    salt = 8'h5A;
    run_xfer(32'd100, 32'd6, 1, 1'b0);        // stalled sink
    run_xfer(32'd7, 32'd0, 0, 1'b0);          // zero count
    run_xfer(32'(DEPTH), 32'd5, 0, 1'b0);     // offset past the window
    run_xfer(32'(DEPTH - 2), 32'd10, 0, 1'b0);// clamped to 2 words
    run_xfer(32'(DEPTH - 3), 32'hFFFF_FFFF, 2, 1'b0);
    run_xfer(32'd50, 32'd5, 0, 1'b1);         // start re-pulsed while busy

    // Reset in the middle of a transfer
    salt = 8'hC3;
    queue_expect(32'd200, 8);
    @(posedge clk); #1;
    start = 1'b1; offset = 32'd200; count = 32'd8; t_start = cyc;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check(mem_re == 0,    "abort_mem_re",    mem_re, 0);
    check(mem_addr == 0,  "abort_mem_addr",  mem_addr, 0);
    check(out_valid == 0, "abort_out_valid", out_valid, 0);
    check(out_data == 0,  "abort_out_data",  out_data, 0);
    check(busy == 0,      "abort_busy",      busy, 0);
    check(done == 0,      "abort_done",      done, 0);
    exp_data_q.delete();
    exp_addr_q.delete();
    base_dones = dones_seen;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (6) @(posedge clk);
    check(dones_seen == base_dones, "no_done_after_abort", dones_seen, base_dones);
    run_xfer(32'd5, 32'd1, 0, 1'b0);

    // Randomized transfers
    for (int t = 0; t < 24; t++) begin
      salt = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       off = 32'(DEPTH) - 32'($urandom_range(0, 6));
        1:       off = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: off = 32'($urandom_range(0, DEPTH - 1));
      endcase
      cnt = 32'($urandom_range(0, 12));
      run_xfer(off, cnt, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
